line_draw_engine: RTL and testbench

- Bresenham line-drawing core that sits directly downstream of the Avalon slave register block.
- Consumes the latched start/end/colour and a one-cycle start pulse, then emits one pixel per accepted cycle to the pixel sink (VGA framebuffer writer).
- Returns a one-cycle done pulse, which releases the controller's stall or poll state.

---
 rtl/lda_pkg.sv | 26 ++
 rtl/lda_setup_unit.sv | 70 +++++++
 rtl/line_draw_engine.sv | 219 +++++++++++++++++++++
 tb/tb_line_draw_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lda_pkg.sv
// Shared widths, FSM state encoding and the Bresenham error type for the
// line_draw_engine block and its setup unit.
package lda_pkg;

    localparam int LDA_X_W   = 9;
    localparam int LDA_Y_W   = 8;
    localparam int LDA_C_W   = 3;
    localparam int LDA_ERR_W = LDA_X_W + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP1 = 3'd1,
        S_SETUP2 = 3'd2,
        S_DRAW   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Two guard bits over the coordinate width keep err in range for any
    // dx/dy the coordinate widths can express.
    typedef logic signed [LDA_ERR_W-1:0] err_t;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lda_setup_unit.sv
// Combinational line setup: steep detection and axis swap, endpoint ordering,
// and dx/dy/ystep/initial-error derivation. All state lives in the parent.
module lda_setup_unit
    import lda_pkg::*;
#(
    parameter int X_W = LDA_X_W,
    parameter int Y_W = LDA_Y_W
) (
    input  logic                  x0_i,
    input  logic [X_W-1:0]        x0_full_i,
    input  logic [X_W-1:0]        y0_i,
    input  logic [X_W-1:0]        x1_i,
    input  logic [X_W-1:0]        y1_i,
    output logic                  steep_o,
    output logic [X_W-1:0]        sw_x0_o,
    output logic [X_W-1:0]        sw_y0_o,
    output logic [X_W-1:0]        sw_x1_o,
    output logic [X_W-1:0]        sw_y1_o,
    output logic [X_W-1:0]        ord_x0_o,
    output logic [X_W-1:0]        ord_y0_o,
    output logic [X_W-1:0]        ord_x1_o,
    output logic [X_W-1:0]        ord_y1_o,
    output logic [X_W-1:0]        dx_o,
    output logic [X_W-1:0]        dy_o,
    output logic                  ystep_neg_o,
    output logic signed [X_W+1:0] err_init_o
);

    localparam int AW = int'(max_w(X_W, Y_W)) + 1;

    logic [X_W-1:0] x0_w;
    logic [AW-1:0]  x0_e;
    logic [AW-1:0]  y0_e;
    logic [AW-1:0]  x1_e;
    logic [AW-1:0]  y1_e;
    logic [AW-1:0]  adx;
    logic [AW-1:0]  ady;
    logic           swap_ord;

    // x0_i is the LSB tap kept only so both stages share one port bundle shape
    assign x0_w = {x0_full_i[X_W-1:1], x0_i};

    assign x0_e = AW'(x0_w);
    assign y0_e = AW'(y0_i);
    assign x1_e = AW'(x1_i);
    assign y1_e = AW'(y1_i);

    assign adx = (x1_e >= x0_e) ? (x1_e - x0_e) : (x0_e - x1_e);
    assign ady = (y1_e >= y0_e) ? (y1_e - y0_e) : (y0_e - y1_e);

    // First setup stage: make x the major axis.
    assign steep_o = (ady > adx);
    assign sw_x0_o = steep_o ? y0_i : x0_w;
    assign sw_y0_o = steep_o ? x0_w : y0_i;
    assign sw_x1_o = steep_o ? y1_i : x1_i;
    assign sw_y1_o = steep_o ? x1_i : y1_i;

    // Second setup stage: walk the major axis in ascending order.
    assign swap_ord = (x0_w > x1_i);
    assign ord_x0_o = swap_ord ? x1_i : x0_w;
    assign ord_y0_o = swap_ord ? y1_i : y0_i;
    assign ord_x1_o = swap_ord ? x0_w : x1_i;
    assign ord_y1_o = swap_ord ? y0_i : y1_i;

    assign dx_o        = ord_x1_o - ord_x0_o;
    assign dy_o        = (ord_y1_o >= ord_y0_o) ? (ord_y1_o - ord_y0_o) : (ord_y0_o - ord_y1_o);
    assign ystep_neg_o = !(ord_y0_o < ord_y1_o);
    assign err_init_o  = -$signed({2'b00, dx_o >> 1});

endmodule

// File: rtl/line_draw_engine.sv
// Bresenham line engine: latches a line on i_start, emits one pixel per
// accepted cycle with i_ready backpressure, then pulses o_done once.
module line_draw_engine
    import lda_pkg::*;
#(
    parameter int X_W = LDA_X_W,
    parameter int Y_W = LDA_Y_W,
    parameter int C_W = LDA_C_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_start,
    input  logic [X_W-1:0] i_x0,
    input  logic [Y_W-1:0] i_y0,
    input  logic [X_W-1:0] i_x1,
    input  logic [Y_W-1:0] i_y1,
    input  logic [C_W-1:0] i_color,
    input  logic           i_ready,
    output logic           o_plot,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic [C_W-1:0] o_color,
    output logic           o_done,
    output logic           o_busy
);

    localparam int ERR_W = X_W + 2;

    state_t state_q;
    state_t state_d;

    logic [X_W-1:0] x0_q, x0_d;
    logic [X_W-1:0] y0_q, y0_d;
    logic [X_W-1:0] x1_q, x1_d;
    logic [X_W-1:0] y1_q, y1_d;
    logic [X_W-1:0] cx_q, cx_d;
    logic [X_W-1:0] cy_q, cy_d;
    logic [X_W-1:0] dx_q, dx_d;
    logic [X_W-1:0] dy_q, dy_d;
    logic           steep_q, steep_d;
    logic           ystep_neg_q, ystep_neg_d;
    logic [C_W-1:0] color_q, color_d;
    logic signed [ERR_W-1:0] err_q, err_d;

    logic signed [ERR_W-1:0] dx_ext;
    logic signed [ERR_W-1:0] dy_ext;
    logic signed [ERR_W-1:0] err_step;
    logic                    err_pos;
    logic [X_W-1:0]          pix_x;
    logic [X_W-1:0]          pix_y;

    logic                    su_steep;
    logic [X_W-1:0]          su_sw_x0, su_sw_y0, su_sw_x1, su_sw_y1;
    logic [X_W-1:0]          su_ord_x0, su_ord_y0, su_ord_x1, su_ord_y1;
    logic [X_W-1:0]          su_dx, su_dy;
    logic                    su_ystep_neg;
    logic signed [ERR_W-1:0] su_err_init;

    lda_setup_unit #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_setup (
        .x0_i        (x0_q[0]),
        .x0_full_i   (x0_q),
        .y0_i        (y0_q),
        .x1_i        (x1_q),
        .y1_i        (y1_q),
        .steep_o     (su_steep),
        .sw_x0_o     (su_sw_x0),
        .sw_y0_o     (su_sw_y0),
        .sw_x1_o     (su_sw_x1),
        .sw_y1_o     (su_sw_y1),
        .ord_x0_o    (su_ord_x0),
        .ord_y0_o    (su_ord_y0),
        .ord_x1_o    (su_ord_x1),
        .ord_y1_o    (su_ord_y1),
        .dx_o        (su_dx),
        .dy_o        (su_dy),
        .ystep_neg_o (su_ystep_neg),
        .err_init_o  (su_err_init)
    );

    assign dx_ext   = $signed({2'b00, dx_q});
    assign dy_ext   = $signed({2'b00, dy_q});
    assign err_step = err_q + dy_ext;
    assign err_pos  = !err_step[ERR_W-1] && (err_step != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_plot  = 1'b0;
        o_done  = 1'b0;
        o_busy  = 1'b1;
        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_d = S_SETUP1;
                end
            end
            S_SETUP1: state_d = S_SETUP2;
            S_SETUP2: state_d = S_DRAW;
            S_DRAW: begin
                o_plot = 1'b1;
                if (i_ready && (cx_q == x1_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        steep_d     = steep_q;
        ystep_neg_d = ystep_neg_q;
        color_d     = color_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    x0_d    = i_x0;
                    y0_d    = X_W'(i_y0);
                    x1_d    = i_x1;
                    y1_d    = X_W'(i_y1);
                    color_d = i_color;
                end
            end
            S_SETUP1: begin
                steep_d = su_steep;
                x0_d    = su_sw_x0;
                y0_d    = su_sw_y0;
                x1_d    = su_sw_x1;
                y1_d    = su_sw_y1;
            end
            S_SETUP2: begin
                x0_d        = su_ord_x0;
                y0_d        = su_ord_y0;
                x1_d        = su_ord_x1;
                y1_d        = su_ord_y1;
                dx_d        = su_dx;
                dy_d        = su_dy;
                ystep_neg_d = su_ystep_neg;
                err_d       = su_err_init;
                cx_d        = su_ord_x0;
                cy_d        = su_ord_y0;
            end
            S_DRAW: begin
                if (i_ready && (cx_q != x1_q)) begin
                    cx_d = cx_q + 1'b1;
                    // Minor-axis step decision uses the error after adding dy.
                    if (err_pos) begin
                        cy_d  = ystep_neg_q ? (cy_q - 1'b1) : (cy_q + 1'b1);
                        err_d = err_step - dx_ext;
                    end else begin
                        err_d = err_step;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            steep_q     <= 1'b0;
            ystep_neg_q <= 1'b0;
            color_q     <= '0;
            err_q       <= '0;
        end else begin
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            steep_q     <= steep_d;
            ystep_neg_q <= ystep_neg_d;
            color_q     <= color_d;
            err_q       <= err_d;
        end
    end

    // Undo the axis swap on the way out; coordinates read as zero when idle.
    assign pix_x   = steep_q ? cy_q : cx_q;
    assign pix_y   = steep_q ? cx_q : cy_q;
    assign o_x     = o_plot ? pix_x : '0;
    assign o_y     = o_plot ? Y_W'(pix_y) : '0;
    assign o_color = color_q;

endmodule

// File: tb/tb_line_draw_engine.sv
// Directed and randomized line tests for line_draw_engine with a pixel scoreboard
// filled from a closed-form Bresenham model.
module tb_line_draw_engine;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    logic           clk     = 1'b0;
    logic           reset   = 1'b1;
    logic           i_start = 1'b0;
    logic           i_ready = 1'b1;
    logic [X_W-1:0] i_x0    = '0;
    logic [Y_W-1:0] i_y0    = '0;
    logic [X_W-1:0] i_x1    = '0;
    logic [Y_W-1:0] i_y1    = '0;
    logic [C_W-1:0] i_color = '0;
    logic           o_plot;
    logic [X_W-1:0] o_x;
    logic [Y_W-1:0] o_y;
    logic [C_W-1:0] o_color;
    logic           o_done;
    logic           o_busy;

    int errors = 0;
    int checks = 0;
    int last_x = -1;
    int last_y = -1;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];

    line_draw_engine #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_x0    (i_x0),
        .i_y0    (i_y0),
        .i_x1    (i_x1),
        .i_y1    (i_y1),
        .i_color (i_color),
        .i_ready (i_ready),
        .o_plot  (o_plot),
        .o_x     (o_x),
        .o_y     (o_y),
        .o_color (o_color),
        .o_done  (o_done),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Minor-axis offset after i major steps is ceil((i*dy - dx/2)/dx), floored at 0.
    task automatic push_line(input int x0, input int y0, input int x1, input int y1, input int c);
        int ax0, ay0, ax1, ay1, t, dx, dy, s, h, n, k;
        bit st;
        pix_t p;
        st  = iabs(y1 - y0) > iabs(x1 - x0);
        ax0 = st ? y0 : x0;
        ay0 = st ? x0 : y0;
        ax1 = st ? y1 : x1;
        ay1 = st ? x1 : y1;
        if (ax0 > ax1) begin
            t = ax0; ax0 = ax1; ax1 = t;
            t = ay0; ay0 = ay1; ay1 = t;
        end
        dx = ax1 - ax0;
        dy = iabs(ay1 - ay0);
        s  = (ay0 < ay1) ? 1 : -1;
        h  = dx / 2;
        for (int i = 0; i <= dx; i++) begin
            n = i * dy - h;
            k = (n <= 0) ? 0 : (n + dx - 1) / dx;
            if (st) begin
                p.x = ay0 + s * k;
                p.y = ax0 + i;
            end else begin
                p.x = ax0 + i;
                p.y = ay0 + s * k;
            end
            p.c = c;
            exp_q.push_back(p);
        end
    endtask

    task automatic run_line(input int x0, input int y0, input int x1, input int y1, input int c,
                            input int stall_from, input int stall_len, input bit rnd_ready,
                            input int restart_at, input int exp_done);
        int   done_cyc;
        pix_t p;
        done_cyc = -1;
        @(posedge clk); #1;
        i_x0    = X_W'(x0);
        i_y0    = Y_W'(y0);
        i_x1    = X_W'(x1);
        i_y1    = Y_W'(y1);
        i_color = C_W'(c);
        i_start = 1'b1;
        i_ready = 1'b1;
        push_line(x0, y0, x1, y1, c);
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            @(posedge clk); #1;
            i_start = (cyc == restart_at);
            i_x0    = X_W'($urandom_range(0, 511));
            i_y0    = Y_W'($urandom_range(0, 255));
            i_x1    = X_W'($urandom_range(0, 511));
            i_y1    = Y_W'($urandom_range(0, 255));
            i_color = C_W'($urandom_range(0, 7));
            if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
            else           i_ready = !((cyc >= stall_from) && (cyc < stall_from + stall_len));
            @(negedge clk);
            check("busy_during_line", o_busy, 1);
            if (cyc < 3) check("no_plot_in_setup", o_plot, 0);
            if (cyc == 3) check("first_plot_cycle3", o_plot, 1);
            if (o_plot) begin
                if (exp_q.size() == 0) begin
                    check("pixel_expected", int'(exp_q.size() != 0), 1);
                end else if (i_ready) begin
                    p = exp_q.pop_front();
                    check("pix_x", o_x, p.x);
                    check("pix_y", o_y, p.y);
                    check("pix_color", o_color, p.c);
                    last_x = o_x;
                    last_y = o_y;
                end else begin
                    check("hold_x", o_x, exp_q[0].x);
                    check("hold_y", o_y, exp_q[0].y);
                end
            end
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
        end
        check("done_seen", int'(done_cyc >= 0), 1);
        check("queue_empty_at_done", exp_q.size(), 0);
        if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
        $display("line (%0d,%0d)->(%0d,%0d) col=%0d done_cycle=%0d", x0, y0, x1, y1, c, done_cyc);
        exp_q.delete();
        @(posedge clk); #1;
        i_start = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check("done_one_cycle", o_done, 0);
        check("idle_after_done", o_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_plot", o_plot, 0);
        check("rst_done", o_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_x", o_x, 0);
        check("rst_y", o_y, 0);
        check("rst_color", o_color, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Horizontal; a start pulse during the done cycle must be ignored
        run_line(0, 0, 3, 0, 1, 0, 0, 1'b0, 7, 7);
        // Steep
        run_line(0, 0, 1, 3, 5, 0, 0, 1'b0, -1, 7);
        // Reversed endpoints
        run_line(3, 0, 0, 0, 2, 0, 0, 1'b0, -1, 7);
        // Single point
        run_line(5, 5, 5, 5, 4, 0, 0, 1'b0, -1, 4);
        // Backpressure on the second pixel for two cycles
        run_line(0, 0, 2, 2, 3, 4, 2, 1'b0, -1, 8);
        // Restart attempt while drawing
        run_line(2, 1, 6, 3, 6, 0, 0, 1'b0, 4, 8);

        // Reset in the middle of a line
        @(posedge clk); #1;
        i_x0 = 9'd0; i_y0 = 8'd0; i_x1 = 9'd3; i_y1 = 8'd0; i_color = 3'd2;
        i_start = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mid_pre_plot", o_plot, 1);
        check("rst_mid_pre_x", o_x, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_plot", o_plot, 0);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_done", o_done, 0);
        check("rst_mid_x", o_x, 0);
        check("rst_mid_y", o_y, 0);
        check("rst_mid_color", o_color, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_no_done", o_done, 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_no_done_after", o_done, 0);
        run_line(0, 0, 3, 0, 6, 0, 0, 1'b0, -1, 7);

        // Extremes
        run_line(0, 0, 319, 239, 7, 0, 0, 1'b0, -1, 323);
        check("extreme_last_x", last_x, 319);
        check("extreme_last_y", last_y, 239);
        run_line(511, 0, 0, 255, 1, 0, 0, 1'b0, -1, 515);
        run_line(10, 200, 3, 20, 2, 0, 0, 1'b0, -1, 184);

        // Random lines with random backpressure
        for (int n = 0; n < 6; n++) begin
            run_line($urandom_range(0, 511), $urandom_range(0, 255),
                     $urandom_range(0, 511), $urandom_range(0, 255),
                     $urandom_range(0, 7), 0, 0, 1'b1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
